// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a valid/ready skid-free pipeline.
// Decode happens ahead of stage 0; later stages only move the result.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      immSrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immOut,
    output logic            immErr,
    output logic [15:0]     err_count
);

    localparam int LAST = STAGES - 1;

    logic [31:0]       imm32;
    logic              dec_err;
    logic [XLEN-1:0]   dec_imm;
    logic              unused_opcode;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] err_q, err_d;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [XLEN-1:0]   imm_d [STAGES];
    logic [STAGES-1:0] ld;
    logic [15:0]       err_count_q, err_count_d;
    logic              out_hs_err;

    assign unused_opcode = ^instr[6:0];

    // Z is built with a clear top bit so one sign-extension serves all formats
    always_comb begin
        imm32   = '0;
        dec_err = 1'b0;
        unique case (1'b1)
            (immSrc == 3'b000): imm32 = {{20{instr[31]}}, instr[31:20]};
            (immSrc == 3'b001): imm32 = {{20{instr[31]}}, instr[31:25],
                                         instr[11:7]};
            (immSrc == 3'b010): imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
            (immSrc == 3'b011): imm32 = {instr[31:12], 12'b0};
            (immSrc == 3'b100): imm32 = {{11{instr[31]}}, instr[31],
                                         instr[19:12], instr[20],
                                         instr[30:21], 1'b0};
            (immSrc == 3'b101): imm32 = {27'b0, instr[19:15]};
            default:            dec_err = 1'b1;
        endcase
        dec_imm = XLEN'($signed(imm32));
    end

    // Load enables ripple back from out_ready so a full pipe still streams
    always_comb begin
        logic nxt;
        ld  = '0;
        nxt = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            ld[k] = !valid_q[k] || nxt;
            nxt   = ld[k];
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = valid_q[LAST];
    assign immOut    = imm_q[LAST];
    assign immErr    = err_q[LAST];

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        for (int k = 0; k < STAGES; k++) begin
            imm_d[k] = imm_q[k];
        end
        if (ld[0]) begin
            valid_d[0] = in_valid;
            imm_d[0]   = dec_imm;
            err_d[0]   = dec_err;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                valid_d[k] = valid_q[k-1];
                imm_d[k]   = imm_q[k-1];
                err_d[k]   = err_q[k-1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // An item leaving in a flush cycle is treated as killed, never counted
    assign out_hs_err = valid_q[LAST] && out_ready && err_q[LAST] && !flush;

    always_comb begin
        err_count_d = err_count_q;
        if (out_hs_err && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            err_q       <= '0;
            err_count_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= imm_d[k];
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances on shared stimulus,
// checked against a queue-based reference model.
module tb_imm_gen_pipe;

    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  immSrc;

    logic        in_ready32, out_valid32, immErr32;
    logic [31:0] immOut32;
    logic [15:0] errc32;
    logic        in_ready64, out_valid64, immErr64;
    logic [63:0] immOut64;
    logic [15:0] errc64;

    imm_gen_pipe #(.XLEN(32), .STAGES(ST)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immSrc(immSrc),
        .out_valid(out_valid32), .out_ready(out_ready),
        .immOut(immOut32), .immErr(immErr32), .err_count(errc32)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(ST)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immSrc(immSrc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .immOut(immOut64), .immErr(immErr64), .err_count(errc64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        int          acc;
    } item_t;

    item_t       q[$];
    int          nchk = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          last_stall = -100;
    int          model_err = 0;
    int          pops = 0;
    logic        last_acc, last_hs;
    logic [31:0] last32;
    logic [63:0] last64;
    logic        lasterr;
    logic        pv = 1'b0;
    logic        prdy = 1'b0;
    logic [31:0] pimm = '0;

    function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] s,
                                            input int xlen);
        longint sx;
        longint v;
        sx = longint'($signed(i));
        case (s)
            3'd0: v = sx >>> 20;
            3'd1: v = (sx >>> 25) * 32 + longint'(i[11:7]);
            3'd2: v = (sx >>> 31) * 4096 + longint'(i[7]) * 2048
                      + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            3'd3: v = sx & -64'sd4096;
            3'd4: v = (sx >>> 31) * 1048576 + longint'(i[19:12]) * 4096
                      + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            3'd5: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        item_t it;
        logic  fl;
        logic  it_err;
        it_err = 1'b0;
        @(negedge clk);
        fl       = flush;
        last_acc = in_valid && in_ready32 && !flush;
        last_hs  = out_valid32 && out_ready;
        chk("in_ready32", {63'b0, in_ready32},
            {63'b0, !(q.size() == ST && !out_ready)});
        chk("in_ready64", {63'b0, in_ready64},
            {63'b0, !(q.size() == ST && !out_ready)});
        chk("err_count32", {48'b0, errc32}, 64'(model_err));
        chk("err_count64", {48'b0, errc64}, 64'(model_err));
        if (q.size() == 0) begin
            chk("phantom32", {63'b0, out_valid32}, 64'd0);
            chk("phantom64", {63'b0, out_valid64}, 64'd0);
        end
        if (pv && !prdy) begin
            chk("hold_valid", {63'b0, out_valid32}, 64'd1);
            chk("hold_imm", {32'b0, immOut32}, {32'b0, pimm});
        end
        if (out_valid32 && !out_ready) last_stall = cyc;
        if (last_hs) begin
            if (q.size() == 0) begin
                chk("spurious_out", {63'b0, out_valid32}, 64'd0);
            end else begin
                it = q.pop_front();
                pops++;
                it_err = (it.src > 3'd5);
                chk("imm32", {32'b0, immOut32}, ref_imm(it.ins, it.src, 32));
                chk("err32", {63'b0, immErr32}, {63'b0, it_err});
                chk("valid64", {63'b0, out_valid64}, 64'd1);
                chk("imm64", immOut64, ref_imm(it.ins, it.src, 64));
                chk("err64", {63'b0, immErr64}, {63'b0, it_err});
                if (last_stall < it.acc)
                    chk("latency", 64'(cyc - it.acc), 64'(ST));
                else
                    chk("latency_min", {63'b0, (cyc - it.acc) >= ST}, 64'd1);
                last32  = immOut32;
                last64  = immOut64;
                lasterr = immErr32;
            end
        end
        pv   = out_valid32;
        prdy = out_ready;
        pimm = immOut32;
        it.ins = instr;
        it.src = immSrc;
        it.acc = cyc;
        @(posedge clk);
        cyc++;
        if (last_hs && it_err && !fl && model_err < 65535) model_err++;
        if (fl) begin
            q.delete();
            pv = 1'b0;
        end
        if (last_acc) q.push_back(it);
        #1;
    endtask

    task automatic send_wait(input logic [31:0] ins, input logic [2:0] src);
        int n;
        instr    = ins;
        immSrc   = src;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 10);
        chk("accept_timeout", {63'b0, last_acc}, 64'd1);
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int t;
        int sent;
        int p0;
        logic [31:0] items [8];
        logic [2:0]  srcs [8];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; immSrc = '0;
        #1;
        chk("rst_out_valid32", {63'b0, out_valid32}, 64'd0);
        chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
        chk("rst_err_count", {48'b0, errc32}, 64'd0);
        chk("rst_imm32", {32'b0, immOut32}, 64'd0);
        chk("rst_imm64", immOut64, 64'd0);
        chk("rst_immerr", {63'b0, immErr32}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {63'b0, in_ready32}, 64'd1);

        send_wait(32'h7F352393, 3'b000);
        chk("I32", {32'b0, last32}, 64'h0000_07F3);
        send_wait(32'h7F352393, 3'b001);
        chk("S32", {32'b0, last32}, 64'h0000_07E7);
        send_wait(32'h7F352393, 3'b010);
        chk("B32", {32'b0, last32}, 64'h0000_0FE6);
        send_wait(32'h7F352393, 3'b011);
        chk("U32", {32'b0, last32}, 64'h7F35_2000);
        send_wait(32'h7F352393, 3'b100);
        chk("J32", {32'b0, last32}, 64'h0005_2FF2);
        send_wait(32'h7F352393, 3'b101);
        chk("Z32", {32'b0, last32}, 64'h0000_000A);

        send_wait(32'h80000093, 3'b000);
        chk("I64", last64, 64'hFFFF_FFFF_FFFF_F800);
        send_wait(32'h80000037, 3'b011);
        chk("U64", last64, 64'hFFFF_FFFF_8000_0000);

        chk("err_before", {48'b0, errc32}, 64'd0);
        send_wait(32'hFFFFFFFF, 3'b110);
        chk("ill_imm", {32'b0, last32}, 64'd0);
        chk("ill_err", {63'b0, lasterr}, 64'd1);
        chk("err_after", {48'b0, errc32}, 64'd1);
        send_wait(32'hFFFFFFFF, 3'b111);
        chk("err_after2", {48'b0, errc32}, 64'd2);

        instr = 32'hFFFFFFFF; immSrc = 3'b110; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("flush_err_keep", {48'b0, errc32}, 64'd2);

        out_ready = 1'b1; in_valid = 1'b1;
        instr = $urandom; immSrc = 3'b000;
        cycle();
        instr = $urandom; immSrc = 3'b001;
        cycle();
        out_ready = 1'b0;
        instr = $urandom; immSrc = 3'b110; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("ready_after_flush", {63'b0, in_ready32}, 64'd1);
        for (int i = 0; i < ST; i++) begin
            chk("flush_quiet", {63'b0, out_valid32}, 64'd0);
            cycle();
        end
        send_wait(32'h7F352393, 3'b100);
        chk("post_flush_J", {32'b0, last32}, 64'h0005_2FF2);
        chk("flush_err_keep2", {48'b0, errc32}, 64'd2);

        for (int i = 0; i < 8; i++) begin
            items[i] = $urandom;
            srcs[i]  = 3'($urandom_range(0, 7));
        end
        p0 = pops; sent = 0; t = 0;
        while (sent < 8 && t < 40) begin
            out_ready = !(t >= 4 && t < 7);
            instr     = items[sent];
            immSrc    = srcs[sent];
            in_valid  = 1'b1;
            cycle();
            if (last_acc) sent++;
            t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 20) begin
            cycle();
            t++;
        end
        chk("stream_count", 64'(pops - p0), 64'd8);

        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            instr     = $urandom;
            immSrc    = 3'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 20) begin
            cycle();
            t++;
        end
        chk("random_drain", 64'(q.size()), 64'd0);

        out_ready = 1'b0; in_valid = 1'b1;
        instr = $urandom; immSrc = 3'b110;
        cycle();
        instr = $urandom; immSrc = 3'b010;
        cycle();
        in_valid = 1'b0;
        chk("full_before_rst", {63'b0, out_valid32}, 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_valid32", {63'b0, out_valid32}, 64'd0);
        chk("async_valid64", {63'b0, out_valid64}, 64'd0);
        chk("async_errc32", {48'b0, errc32}, 64'd0);
        chk("async_errc64", {48'b0, errc64}, 64'd0);
        q.delete();
        model_err = 0;
        pv = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst2", {63'b0, in_ready32}, 64'd1);
        chk("idle_after_rst2", {63'b0, out_valid32}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_wait(32'h80000093, 3'b000);
        chk("I32_after_rst", {32'b0, last32}, 64'hFFFF_F800);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning output immediate width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline depth; legal range is 1..4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream holds a valid instr/immSrc.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-008 The block SHALL have port instr, input, 32 bits: raw RISC-V instruction word.
REQ-009 The block SHALL have port immSrc, input, 3 bits: format select, with 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR uimm), and 110/111 illegal.
REQ-010 The block SHALL have port out_valid, output, 1 bit: immOut/immErr are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts output.
REQ-012 The block SHALL have port immOut, output, XLEN bits: the decoded immediate.
REQ-013 The block SHALL have port immErr, output, 1 bit: the item carried an illegal immSrc.
REQ-014 The block SHALL have port err_count, output, 16 bits: count of illegal items delivered.

Function
REQ-015 Decode SHALL follow these rules, all sign-extended from instr[31] to XLEN:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-016 Z format SHALL zero-extend instr[19:15] to XLEN.
REQ-017 An illegal immSrc SHALL produce immOut = 0 and immErr = 1; every legal format SHALL produce immErr = 0.
REQ-018 Decode SHALL be performed before stage 0 and the result registered; stages 1..STAGES-1 SHALL only shift the result.
REQ-019 Each stage SHALL hold a valid bit; the stage k register loads when stage k is empty or stage k+1 (or the output for the last stage) advances this cycle.
REQ-020 The input SHALL be accepted when in_valid && in_ready; in_ready = !valid[0] || stage 0 advances (combinational from out_ready through the chain).
REQ-021 An accepted item SHALL appear at out_valid exactly STAGES cycles after acceptance when out_ready is held high, giving a throughput of 1 item per cycle.
REQ-022 While out_valid && !out_ready, immOut and immErr SHALL stay stable and no item SHALL be lost or duplicated; bubbles SHALL collapse behind a stall.
REQ-023 On flush, all valid bits SHALL clear at the next edge, any input presented in that cycle SHALL be dropped (not counted as accepted), and data registers are don't-care.
REQ-024 The block SHALL accept new input on the cycle after a flush.
REQ-025 err_count SHALL increment by 1 on each output handshake with immErr = 1, and SHALL saturate at 0xFFFF with no wrap.
REQ-026 A flushed item SHALL never be counted in err_count.

Reset
REQ-027 rst high SHALL asynchronously clear all valid bits, immOut, immErr and err_count to 0, so out_valid = 0.
REQ-028 in_ready SHALL be 1 after reset deassertion.
REQ-029 A reset asserted mid-stream SHALL discard all in-flight items immediately, without waiting for a clock edge.

Verification
REQ-030 With XLEN=32, STAGES=2, out_ready=1 and instr=0x7F352393, the bench SHALL check each format in turn: I -> 0x000007F3; S -> 0x000007E7; U -> 0x7F352000; Z -> 0x0000000A; each exactly 2 cycles after acceptance.
REQ-031 With XLEN=64, the bench SHALL check: instr=0x80000093 as I -> 0xFFFFFFFFFFFFF800; instr=0x80000037 as U -> 0xFFFFFFFF80000000.
REQ-032 The bench SHALL stream 8 back-to-back items while holding out_ready low for 3 cycles mid-stream, and check that all 8 exit in order with held values stable and in_ready low only while the pipe is full.
REQ-033 The bench SHALL send immSrc=110 with instr=0xFFFFFFFF and check immOut=0, immErr=1, and err_count 0 -> 1 on the handshake; a flush on an illegal item in flight SHALL leave err_count unchanged.
REQ-034 The bench SHALL assert flush with 2 items in flight plus 1 presented, and check out_valid=0 for the next STAGES cycles and that the next accepted item emerges correctly.
REQ-035 The bench SHALL assert rst between clock edges while the pipe is full, and check that out_valid and err_count drop to 0 immediately and in_ready=1 after deassertion.
